// File: rtl/shift_unit_seq.sv
// ---------------------------------------------------------------------------
// shift_unit_seq
//
// Multi-cycle shift unit for the EX stage. It performs SLL, SRL, SRA and ROR,
// moving STEP bit positions per clock. A start/busy/done handshake lets the
// control unit stall the pipeline until the shift has finished.
//
// The shift amount comes from one of two places:
//   - the instruction shamt field, zero-extended or truncated to SHAMT_W bits
//   - the low SHAMT_W bits of a register operand
//
// Parameters:
//   WIDTH   - datapath width. Must equal 2**SHAMT_W.
//   SHAMT_W - width of the shift amount.
//   STEP    - bit positions shifted per cycle. Power of two, 1..WIDTH.
//
// Ports:
//   clk         - rising-edge clock
//   reset       - asynchronous, active-high reset
//   start       - operation request. It is sampled only while not busy.
//   op          - 00=SLL, 01=SRL, 10=SRA, 11=ROR
//   shamt_sel   - 0 selects shamt_field, 1 selects shamt_reg[SHAMT_W-1:0]
//   shamt_field - instruction shamt field (5 bits)
//   shamt_reg   - register operand (rs). Only the low SHAMT_W bits are used.
//   data_in     - operand to shift (rt)
//   busy        - high while the shift is iterating
//   done        - one-cycle pulse when result is valid
//   result      - working/result register. It holds its value after done.
// ---------------------------------------------------------------------------
module shift_unit_seq #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5,
    parameter int STEP    = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             shamt_sel,
    input  logic [4:0]       shamt_field,
    input  logic [WIDTH-1:0] shamt_reg,
    input  logic [WIDTH-1:0] data_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Arithmetic on the remaining count uses one extra bit. This lets STEP,
    // which may equal WIDTH, be represented without overflow.
    localparam logic [SHAMT_W:0] STEP_V  = (SHAMT_W + 1)'(STEP);
    localparam logic [SHAMT_W:0] WIDTH_V = (SHAMT_W + 1)'(WIDTH);

    state_t             state, state_n;
    logic [WIDTH-1:0]   result_n;
    logic [SHAMT_W-1:0] count, count_n;
    logic [1:0]         op_q, op_n;

    logic [SHAMT_W-1:0] field_s;
    logic [SHAMT_W-1:0] shamt_s;
    logic [SHAMT_W:0]   count_ext;
    logic [SHAMT_W:0]   k;
    logic [SHAMT_W:0]   rem;
    logic [WIDTH-1:0]   stepped;

    // Fit the fixed 5-bit instruction field to SHAMT_W. Wider amounts are
    // zero-extended and narrower ones are truncated.
    generate
        if (SHAMT_W > 5) begin : g_field_ext
            assign field_s = {{(SHAMT_W - 5){1'b0}}, shamt_field};
        end else begin : g_field_trunc
            assign field_s = shamt_field[SHAMT_W-1:0];
        end
    endgenerate

    // Only the low bits of the register operand can affect the shift.
    logic unused_reg_bits;
    assign unused_reg_bits = ^shamt_reg[WIDTH-1:SHAMT_W];

    assign shamt_s = shamt_sel ? shamt_reg[SHAMT_W-1:0] : field_s;

    // One iteration moves k = min(STEP, count) positions, so the last
    // iteration never overshoots the requested amount.
    assign count_ext = {1'b0, count};
    assign k         = (count_ext < STEP_V) ? count_ext : STEP_V;
    assign rem       = count_ext - k;

    // Single-iteration shifter driven by the latched opcode. In the rotate
    // case k is never zero while shifting, so WIDTH-k stays below WIDTH.
    always_comb begin
        stepped = result;
        case (op_q)
            2'b00:   stepped = result << k;
            2'b01:   stepped = result >> k;
            2'b10:   stepped = $unsigned($signed(result) >>> k);
            default: stepped = (result >> k) | (result << (WIDTH_V - k));
        endcase
    end

    // Next-state and datapath update.
    // In IDLE and DONE the unit may accept a new request. That allows a
    // back-to-back start straight out of DONE. Zero-length shifts skip SHIFT
    // and go directly to DONE with the operand unchanged.
    always_comb begin
        state_n  = state;
        result_n = result;
        count_n  = count;
        op_n     = op_q;
        case (state)
            SHIFT: begin
                result_n = stepped;
                count_n  = rem[SHAMT_W-1:0];
                if (rem == '0) begin
                    state_n = DONE;
                end
            end
            default: begin
                if (start) begin
                    result_n = data_in;
                    op_n     = op;
                    count_n  = shamt_s;
                    state_n  = (shamt_s == '0) ? DONE : SHIFT;
                end else if (state == DONE) begin
                    state_n = IDLE;
                end
            end
        endcase
    end

    // State and datapath registers.
    // Reset clears everything at any time, including in the middle of a
    // shift, and the next request after reset starts from a clean state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            result <= '0;
            count  <= '0;
            op_q   <= 2'b00;
        end else begin
            state  <= state_n;
            result <= result_n;
            count  <= count_n;
            op_q   <= op_n;
        end
    end

    assign busy = (state == SHIFT);
    assign done = (state == DONE);

endmodule

// File: doc/shift_unit_seq.md
Name: shift_unit_seq

Overview:
- Multi-cycle, parametrised shift unit for the EX stage. Successor to the combinational shamt zero-extender.
- Selects the shift amount from either the instruction shamt field (zero-extended) or the low bits of a register operand.
- Performs SLL/SRL/SRA and adds rotate-right (ROR).
- Iterates STEP bit positions per cycle under a start/busy/done handshake, so the control unit can stall while a shift completes.

Parameters:
- WIDTH, 32, datapath width in bits.
- SHAMT_W, 5, shift-amount width. Must satisfy 2^SHAMT_W == WIDTH.
- STEP, 1, bit positions shifted per cycle. Power of two, 1..WIDTH.

Ports:
- clk  input  1  clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only when not busy.
- op  input  2  00=SLL, 01=SRL, 10=SRA, 11=ROR.
- shamt_sel  input  1  0=use shamt_field, 1=use shamt_reg[SHAMT_W-1:0].
- shamt_field  input  5  instruction shamt field; zero-extended (or truncated) to SHAMT_W.
- shamt_reg  input  WIDTH  register operand (rs); only low SHAMT_W bits used.
- data_in  input  WIDTH  operand to shift (rt).
- busy  output  1  high while state==SHIFT.
- done  output  1  one-cycle pulse; result valid.
- result  output  WIDTH  working/result register.

Behaviour:
- States: IDLE, SHIFT, DONE. Encoding free.
- Reset (async, any time, including mid-operation):
  - state=IDLE, result=0, busy=0, done=0, internal count=0, op reg=0.
  - Next start is accepted normally after reset deasserts.
- Start acceptance:
  - start is accepted on a rising edge when state is IDLE or DONE.
  - On acceptance: result<=data_in, op latched, count<=selected shamt (s).
  - Next state is SHIFT if s!=0, DONE if s==0.
- start while busy (state SHIFT) is ignored. Latched operands are unaffected; no queuing.
- SHIFT, on each edge:
  - k=min(STEP,count).
  - result<=result shifted by k per the latched op; count<=count-k.
  - When count-k==0, next state is DONE; otherwise remain in SHIFT.
- Shift semantics per step:
  - SLL: fill 0 from the LSB side.
  - SRL: fill 0 from the MSB side.
  - SRA: fill with result[WIDTH-1].
  - ROR: bits leaving the LSB re-enter at the MSB.
- DONE:
  - done=1 for exactly one cycle; busy=0.
  - Next edge goes to SHIFT/DONE if start is high (back-to-back accepted), else IDLE.
- result holds its value in IDLE and DONE until the next accepted start. Its value during SHIFT is intermediate and not architecturally valid.
- Latency, measured from the edge sampling start to the first cycle done is high:
  - n=ceil(s/STEP) plus 1 cycle.
  - s==0 gives 1 cycle, with result==data_in.
- The selected shamt is captured at acceptance. Later changes to shamt_* or data_in have no effect on the operation in flight.
- Maximum shift is WIDTH-1. With WIDTH=32, STEP=1, s=31, done arrives 32 cycles after start.
- busy and done are never high in the same cycle.

Test Plan:
- Config WIDTH=32, STEP=1. SRA: data_in=0x80000000, shamt_sel=0, shamt_field=4 -> busy for 4 cycles, done in cycle 5 after start, result=0xF8000000.
- Config WIDTH=32, STEP=4. ROR: data_in=0x12345678, shamt_field=8 -> 2 busy cycles, done 3 cycles after start, result=0x78123456. Repeat SLL of 0x00000001 by 31 -> result=0x80000000, done after 9 cycles.
- Config WIDTH=32, STEP=1. shamt_sel=1, shamt_reg=0xFFFFFFE3, SRL: data_in=0x000000F0 -> effective shamt 3, result=0x0000001E.
- Config WIDTH=32, STEP=1. shamt_field=0, SLL: data_in=0xDEADBEEF -> no busy cycle, done 1 cycle after start, result=0xDEADBEEF.
- start re-asserted with data_in=0xFFFFFFFF during busy of an SRL of 0x00000100 by 8 -> the second request is ignored and result=0x00000001. Then start held high through DONE -> the new operation is accepted back-to-back with no IDLE cycle.
- reset pulsed mid-SHIFT (cycle 2 of a 10-cycle op) -> immediately busy=0, done=0, result=0. A following start gives a correct result.
